// File: rtl/input_line_buffer.sv
// Three-row line buffer: loads pixel rows from an AXI-Stream input and presents
// vertical 3-pixel columns (top/mid/bot) to a processing element.
module input_line_buffer #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_IMAGE_SIZE = 128
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [7:0]            IMAGE_SIZE,
  input  logic                  Stream_first_row,
  input  logic                  Stream_mid_row,
  input  logic                  Stream_last_row,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] win_top,
  output logic [DATA_WIDTH-1:0] win_mid,
  output logic [DATA_WIDTH-1:0] win_bot,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  win_first_col,
  output logic                  win_last_col,
  output logic                  Done_1row,
  output logic                  Input_line_buffer_IDLE,
  output logic                  err_tlast
);

  localparam int AW = (MAX_IMAGE_SIZE > 1) ? $clog2(MAX_IMAGE_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            p_q, p_d;
  logic [7:0]            size_q, size_d;
  logic [1:0]            wbank_q, wbank_d;
  logic [7:0]            wcol_q, wcol_d;
  logic [8:0]            load_rem_q, load_rem_d;
  logic                  op_first_q, op_first_d;
  logic                  op_last_q, op_last_d;
  logic                  err_q, err_d;
  logic [7:0]            rcol_q, rcol_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic                  first_col_q, first_col_d;
  logic                  last_col_q, last_col_d;

  logic [DATA_WIDTH-1:0] bank0 [MAX_IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] bank1 [MAX_IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] bank2 [MAX_IMAGE_SIZE];

  logic                  wr_en;
  logic [7:0]            rd_col;
  logic                  rd_load;
  logic [DATA_WIDTH-1:0] rd0, rd1, rd2;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sel3(input logic [1:0] i,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b,
                                                 input logic [DATA_WIDTH-1:0] c);
    case (i)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  assign wr_en = (state_q == S_LOAD) && s_axis_tvalid && !Reset;

  // Bank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (wbank_q)
        2'd0:    bank0[wcol_q[AW-1:0]] <= s_axis_tdata;
        2'd1:    bank1[wcol_q[AW-1:0]] <= s_axis_tdata;
        default: bank2[wcol_q[AW-1:0]] <= s_axis_tdata;
      endcase
    end
  end

  assign rd0 = bank0[rd_col[AW-1:0]];
  assign rd1 = bank1[rd_col[AW-1:0]];
  assign rd2 = bank2[rd_col[AW-1:0]];

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      p_q         <= 2'd0;
      size_q      <= 8'd0;
      wbank_q     <= 2'd0;
      wcol_q      <= 8'd0;
      load_rem_q  <= 9'd0;
      op_first_q  <= 1'b0;
      op_last_q   <= 1'b0;
      err_q       <= 1'b0;
      rcol_q      <= 8'd0;
      valid_q     <= 1'b0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      first_col_q <= 1'b0;
      last_col_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      size_q      <= size_d;
      wbank_q     <= wbank_d;
      wcol_q      <= wcol_d;
      load_rem_q  <= load_rem_d;
      op_first_q  <= op_first_d;
      op_last_q   <= op_last_d;
      err_q       <= err_d;
      rcol_q      <= rcol_d;
      valid_q     <= valid_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      first_col_q <= first_col_d;
      last_col_q  <= last_col_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    size_d      = size_q;
    wbank_d     = wbank_q;
    wcol_d      = wcol_q;
    load_rem_d  = load_rem_q;
    op_first_d  = op_first_q;
    op_last_d   = op_last_q;
    err_d       = err_q;
    rcol_d      = rcol_q;
    valid_d     = valid_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    first_col_d = first_col_q;
    last_col_d  = last_col_q;
    rd_col      = 8'd0;
    rd_load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Stream_first_row) begin
          p_d        = 2'd0;
          size_d     = IMAGE_SIZE;
          load_rem_d = {IMAGE_SIZE, 1'b0} - 9'd1;
          wbank_d    = 2'd0;
          wcol_d     = 8'd0;
          rcol_d     = 8'd0;
          op_first_d = 1'b1;
          op_last_d  = 1'b0;
          state_d    = S_LOAD;
        end else if (Stream_mid_row) begin
          p_d        = inc3(p_q);
          size_d     = IMAGE_SIZE;
          load_rem_d = {1'b0, IMAGE_SIZE} - 9'd1;
          wbank_d    = inc3(inc3(p_q));
          wcol_d     = 8'd0;
          rcol_d     = 8'd0;
          op_first_d = 1'b0;
          op_last_d  = 1'b0;
          state_d    = S_LOAD;
        end else if (Stream_last_row) begin
          p_d        = inc3(p_q);
          size_d     = IMAGE_SIZE;
          rcol_d     = 8'd0;
          op_first_d = 1'b0;
          op_last_d  = 1'b1;
          state_d    = S_EMIT;
        end
      end

      S_LOAD: begin
        if (s_axis_tvalid) begin
          // Word count alone ends the load; tlast is only checked.
          if (s_axis_tlast != (load_rem_q == 9'd0)) err_d = 1'b1;
          if (load_rem_q == 9'd0) state_d = S_EMIT;
          else                    load_rem_d = load_rem_q - 9'd1;
          if (wcol_q == size_q - 8'd1) begin
            wcol_d  = 8'd0;
            wbank_d = inc3(wbank_q);
          end else begin
            wcol_d = wcol_q + 8'd1;
          end
        end
      end

      S_EMIT: begin
        if (!valid_q) begin
          rd_col  = 8'd0;
          rd_load = 1'b1;
        end else if (win_ready) begin
          if (rcol_q == size_q - 8'd1) begin
            valid_d     = 1'b0;
            first_col_d = 1'b0;
            last_col_d  = 1'b0;
            state_d     = S_DONE;
          end else begin
            rd_col  = rcol_q + 8'd1;
            rd_load = 1'b1;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (rd_load) begin
      valid_d     = 1'b1;
      rcol_d      = rd_col;
      top_d       = op_first_q ? '0 : sel3(inc3(inc3(p_q)), rd0, rd1, rd2);
      mid_d       = sel3(p_q, rd0, rd1, rd2);
      bot_d       = op_last_q ? '0 : sel3(inc3(p_q), rd0, rd1, rd2);
      first_col_d = (rd_col == 8'd0);
      last_col_d  = (rd_col == size_q - 8'd1);
    end
  end

  assign s_axis_tready          = (state_q == S_LOAD);
  assign win_top                = top_q;
  assign win_mid                = mid_q;
  assign win_bot                = bot_q;
  assign win_valid              = valid_q;
  assign win_first_col          = first_col_q;
  assign win_last_col           = last_col_q;
  assign Done_1row              = (state_q == S_DONE);
  assign Input_line_buffer_IDLE = (state_q == S_IDLE);
  assign err_tlast              = err_q;

endmodule
